// File: rtl/sadd_tree_acc.sv
`default_nettype none
// ============================================================================
// Module      : sadd_tree_acc
// Description : Pipelined signed summation of N_IN lanes through a registered
//               binary adder tree, followed by an output stage that passes,
//               accumulates (wrapping or saturating) the tree sum.
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous active-high reset
//               in_data   - N_IN packed signed lanes of IN_W bits
//               in_valid  - sample present this cycle
//               acc_mode  - 1: add tree sum into the accumulator
//               acc_clr   - 1: start a new accumulation, clear ovf
//               out_data  - signed OUT_W result
//               out_valid - one-cycle pulse per output sample
//               ovf       - sticky accumulator overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module sadd_tree_acc #(
    parameter int N_IN  = 16,
    parameter int IN_W  = 8,
    parameter int OUT_W = 32,
    parameter int SAT   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_IN*IN_W-1:0]     in_data,
    input  logic                     in_valid,
    input  logic                     acc_mode,
    input  logic                     acc_clr,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid,
    output logic                     ovf
);

    localparam int C_STAGES = (N_IN > 1) ? $clog2(N_IN) : 0;

    // Number of partial sums held at tree level s.
    function automatic int f_cnt(input int s);
        return (N_IN + (1 << s) - 1) >> s;
    endfunction

    // Bit offset of tree level s inside the flat w_tree vector.
    function automatic int f_off(input int s);
        int acc;
        acc = 0;
        for (int t = 0; t < s; t++) begin
            acc = acc + f_cnt(t) * OUT_W;
        end
        return acc;
    endfunction

    localparam int C_TREE_W = f_off(C_STAGES + 1);

    generate
        if (N_IN < 1 || OUT_W < IN_W + C_STAGES) begin : g_param_err
            $error("sadd_tree_acc: need N_IN >= 1 and OUT_W >= IN_W + clog2(N_IN)");
        end
    endgenerate

    // All tree levels packed back to back; level 0 is the sign-extended input.
    logic [C_TREE_W-1:0] w_tree;
    logic [C_STAGES:0]   w_v;
    logic [C_STAGES:0]   w_mode;
    logic [C_STAGES:0]   w_clr;

    genvar gs, gj;
    generate
        for (gj = 0; gj < N_IN; gj++) begin : g_lane
            assign w_tree[gj*OUT_W +: OUT_W] = OUT_W'($signed(in_data[gj*IN_W +: IN_W]));
        end
        assign w_v[0]    = in_valid;
        assign w_mode[0] = acc_mode;
        assign w_clr[0]  = acc_clr;

        for (gs = 1; gs <= C_STAGES; gs++) begin : g_stage
            localparam int C_NP   = f_cnt(gs - 1);
            localparam int C_NC   = f_cnt(gs);
            localparam int C_PREV = f_off(gs - 1);
            localparam int C_CUR  = f_off(gs);

            logic [C_NC*OUT_W-1:0] w_next;
            logic [C_NC*OUT_W-1:0] r_sum;
            logic                  r_v;
            logic                  r_mode;
            logic                  r_clr;

            for (gj = 0; gj < C_NC; gj++) begin : g_node
                if (2*gj + 1 < C_NP) begin : g_pair
                    assign w_next[gj*OUT_W +: OUT_W] =
                        w_tree[C_PREV + (2*gj)*OUT_W +: OUT_W] +
                        w_tree[C_PREV + (2*gj+1)*OUT_W +: OUT_W];
                end else begin : g_pass
                    // Odd leftover goes through unchanged to keep stage alignment.
                    assign w_next[gj*OUT_W +: OUT_W] = w_tree[C_PREV + (2*gj)*OUT_W +: OUT_W];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sum  <= '0;
                    r_v    <= 1'b0;
                    r_mode <= 1'b0;
                    r_clr  <= 1'b0;
                end else begin
                    r_sum  <= w_next;
                    r_v    <= w_v[gs-1];
                    r_mode <= w_mode[gs-1];
                    r_clr  <= w_clr[gs-1];
                end
            end

            assign w_tree[C_CUR +: C_NC*OUT_W] = r_sum;
            assign w_v[gs]    = r_v;
            assign w_mode[gs] = r_mode;
            assign w_clr[gs]  = r_clr;
        end
    endgenerate

    // Output stage: accumulate at OUT_W+1 bits so overflow is visible as a
    // mismatch between the two top bits.
    logic [OUT_W-1:0] w_t;
    logic [OUT_W:0]   w_r;
    logic             w_of;
    logic [OUT_W-1:0] w_sat;

    assign w_t   = w_tree[f_off(C_STAGES) +: OUT_W];
    assign w_r   = {out_data[OUT_W-1], out_data} + {w_t[OUT_W-1], w_t};
    assign w_of  = w_r[OUT_W] ^ w_r[OUT_W-1];
    assign w_sat = w_r[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= w_v[C_STAGES];
            if (w_v[C_STAGES]) begin
                if (w_clr[C_STAGES]) begin
                    out_data <= w_t;
                    ovf      <= 1'b0;
                end else if (w_mode[C_STAGES]) begin
                    out_data <= (w_of && SAT != 0) ? w_sat : w_r[OUT_W-1:0];
                    if (w_of) begin
                        ovf <= 1'b1;
                    end
                end else begin
                    out_data <= w_t;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sadd_tree_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_sadd_tree_acc
// Description : Directed self-checking bench for sadd_tree_acc. Four instances:
//               default 16x8->32, 12-bit saturating, 12-bit wrapping, 5 lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sadd_tree_acc;

    logic         clk;
    logic         rst;
    logic [127:0] in16;
    logic         v16, m16, c16;
    logic [39:0]  in5;
    logic         v5, m5, c5;

    logic [31:0]  od16;
    logic         ov16, of16;
    logic [11:0]  od_s1, od_s0;
    logic         ov_s1, of_s1, ov_s0, of_s0;
    logic [31:0]  od5;
    logic         ov5, of5;

    int checks = 0;
    int errors = 0;

    sadd_tree_acc #(.N_IN(16), .IN_W(8), .OUT_W(32), .SAT(0)) u_d16 (
        .clk(clk), .rst(rst), .in_data(in16), .in_valid(v16), .acc_mode(m16),
        .acc_clr(c16), .out_data(od16), .out_valid(ov16), .ovf(of16));

    sadd_tree_acc #(.N_IN(16), .IN_W(8), .OUT_W(12), .SAT(1)) u_s1 (
        .clk(clk), .rst(rst), .in_data(in16), .in_valid(v16), .acc_mode(m16),
        .acc_clr(c16), .out_data(od_s1), .out_valid(ov_s1), .ovf(of_s1));

    sadd_tree_acc #(.N_IN(16), .IN_W(8), .OUT_W(12), .SAT(0)) u_s0 (
        .clk(clk), .rst(rst), .in_data(in16), .in_valid(v16), .acc_mode(m16),
        .acc_clr(c16), .out_data(od_s0), .out_valid(ov_s0), .ovf(of_s0));

    sadd_tree_acc #(.N_IN(5), .IN_W(8), .OUT_W(32), .SAT(0)) u_d5 (
        .clk(clk), .rst(rst), .in_data(in5), .in_valid(v5), .acc_mode(m5),
        .acc_clr(c5), .out_data(od5), .out_valid(ov5), .ovf(of5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set16(input logic [7:0] val);
        for (int i = 0; i < 16; i++) in16[i*8 +: 8] = val;
    endtask

    task automatic drv16(input logic v, input logic m, input logic c);
        v16 = v; m16 = m; c16 = c;
    endtask

    task automatic test_reset();
        if (od16 !== 32'd0) begin errors++; $display("FAIL reset_out_data got %0d want 0", od16); end
        checks++;
        if (ov16 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov16); end
        checks++;
        if (of16 !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", of16); end
        checks++;
        if (od_s1 !== 12'd0 || ov5 !== 1'b0) begin
            errors++; $display("FAIL reset_other got %0d/%b want 0/0", od_s1, ov5);
        end
        checks++;
    endtask

    task automatic test_basic();
        int pulses;
        pulses = 0;
        set16(8'd1); drv16(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            cyc(); drv16(1'b0, 1'b0, 1'b0);
            if (ov16) pulses++;
            if (ov16 !== (c == 4)) begin
                errors++; $display("FAIL basic_valid c=%0d got %b want %b", c, ov16, (c == 4));
            end
            checks++;
            if (c == 4) begin
                if (od16 !== 32'd16) begin errors++; $display("FAIL basic_data got %0d want 16", $signed(od16)); end
                checks++;
            end
        end
        if (pulses != 1) begin errors++; $display("FAIL basic_pulses got %0d want 1", pulses); end
        checks++;
    endtask

    task automatic test_extremes();
        for (int c = 0; c < 7; c++) begin
            if (c == 0)      begin set16(8'h80); drv16(1'b1, 1'b0, 1'b0); end
            else if (c == 1) begin set16(8'h7F); drv16(1'b1, 1'b0, 1'b0); end
            else             drv16(1'b0, 1'b0, 1'b0);
            cyc();
            if (c == 4) begin
                if (ov16 !== 1'b1 || od16 !== 32'hFFFF_F800) begin
                    errors++; $display("FAIL ext_neg got %b/%0d want 1/-2048", ov16, $signed(od16));
                end
                checks++;
            end
            if (c == 5) begin
                if (ov16 !== 1'b1 || od16 !== 32'd2032) begin
                    errors++; $display("FAIL ext_pos got %b/%0d want 1/2032", ov16, $signed(od16));
                end
                checks++;
            end
            if (of16 !== 1'b0) begin errors++; $display("FAIL ext_ovf c=%0d got %b want 0", c, of16); end
            checks++;
        end
    endtask

    task automatic test_accum();
        logic        exp_v  [10];
        logic [31:0] exp_d  [10];
        exp_v = '{0,0,0,0,1,1,0,0,1,0};
        exp_d = '{0,0,0,0,100,200,200,200,300,300};
        set16(8'd0); in16[7:0] = 8'd100;
        for (int c = 0; c < 10; c++) begin
            case (c)
                0:       drv16(1'b1, 1'b0, 1'b1);
                1, 4:    drv16(1'b1, 1'b1, 1'b0);
                default: drv16(1'b0, 1'b0, 1'b0);
            endcase
            cyc();
            if (ov16 !== exp_v[c]) begin
                errors++; $display("FAIL acc_valid c=%0d got %b want %b", c, ov16, exp_v[c]);
            end
            checks++;
            if (c >= 4) begin
                if (od16 !== exp_d[c]) begin
                    errors++; $display("FAIL acc_data c=%0d got %0d want %0d", c, $signed(od16), exp_d[c]);
                end
                checks++;
            end
        end
    endtask

    task automatic test_sat();
        for (int c = 0; c < 7; c++) begin
            case (c)
                0:       begin set16(8'h7F); drv16(1'b1, 1'b0, 1'b1); end
                1:       begin set16(8'h7F); drv16(1'b1, 1'b1, 1'b0); end
                2:       begin set16(8'h01); drv16(1'b1, 1'b0, 1'b1); end
                default: drv16(1'b0, 1'b0, 1'b0);
            endcase
            cyc();
            if (c == 4) begin
                if (od_s1 !== 12'd2032 || of_s1 !== 1'b0 || od_s0 !== 12'd2032 || of_s0 !== 1'b0) begin
                    errors++; $display("FAIL sat_first got s1=%0d/%b s0=%0d/%b want 2032/0 2032/0",
                                       od_s1, of_s1, od_s0, of_s0);
                end
                checks++;
            end
            if (c == 5) begin
                if (od_s1 !== 12'd2047 || of_s1 !== 1'b1) begin
                    errors++; $display("FAIL sat_clamp got %0d/%b want 2047/1", od_s1, of_s1);
                end
                checks++;
                if (od_s0 !== 12'hFE0 || of_s0 !== 1'b1) begin
                    errors++; $display("FAIL sat_wrap got %0d/%b want -32/1", $signed(od_s0), of_s0);
                end
                checks++;
            end
            if (c == 6) begin
                if (od_s1 !== 12'd16 || of_s1 !== 1'b0 || od_s0 !== 12'd16 || of_s0 !== 1'b0) begin
                    errors++; $display("FAIL sat_clr got s1=%0d/%b s0=%0d/%b want 16/0 16/0",
                                       od_s1, of_s1, od_s0, of_s0);
                end
                checks++;
            end
        end
    endtask

    task automatic test_odd();
        in5 = {8'd5, 8'hFC, 8'd3, 8'hFE, 8'd1};
        m5 = 1'b0; c5 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            v5 = (c < 8);
            cyc();
            if (ov5 !== (c >= 3 && c <= 10)) begin
                errors++; $display("FAIL odd_valid c=%0d got %b want %b", c, ov5, (c >= 3 && c <= 10));
            end
            checks++;
            if (c >= 3 && c <= 10) begin
                if (od5 !== 32'd3) begin errors++; $display("FAIL odd_data c=%0d got %0d want 3", c, $signed(od5)); end
                checks++;
            end
        end
        v5 = 1'b0;
    endtask

    task automatic test_reset_mid();
        set16(8'h7F);
        for (int c = 0; c < 6; c++) begin
            drv16(1'b1, (c != 0), (c == 0));
            cyc();
        end
        drv16(1'b0, 1'b0, 1'b0);
        if (ov16 !== 1'b1 || of_s0 !== 1'b1) begin
            errors++; $display("FAIL rmid_pre got %b/%b want 1/1", ov16, of_s0);
        end
        checks++;
        #2 rst = 1'b1;
        #1;
        if (ov16 !== 1'b0 || od16 !== 32'd0) begin
            errors++; $display("FAIL rmid_out got %b/%0d want 0/0", ov16, od16);
        end
        checks++;
        if (of_s0 !== 1'b0 || od_s0 !== 12'd0) begin
            errors++; $display("FAIL rmid_ovf got %b/%0d want 0/0", of_s0, od_s0);
        end
        checks++;
        @(posedge clk);
        #3 rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (ov16 !== 1'b0) begin errors++; $display("FAIL rmid_stale c=%0d got %b want 0", c, ov16); end
            checks++;
        end
        set16(8'd3); drv16(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            cyc(); drv16(1'b0, 1'b0, 1'b0);
            if (ov16 !== (c == 4)) begin
                errors++; $display("FAIL rmid_lat c=%0d got %b want %b", c, ov16, (c == 4));
            end
            checks++;
            if (c == 4) begin
                if (od16 !== 32'd48) begin errors++; $display("FAIL rmid_data got %0d want 48", $signed(od16)); end
                checks++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in16 = '0; v16 = 1'b0; m16 = 1'b0; c16 = 1'b0;
        in5 = '0;  v5 = 1'b0;  m5 = 1'b0;  c5 = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_basic();
        test_extremes();
        test_accum();
        test_sat();
        test_odd();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
